param_register_file: RTL and testbench
======================================

# param_register_file

Parametrised successor to the 16x16 register file: configurable data width and register count, two combinational read ports, one synchronous write port. Adds a per-register busy scoreboard for multi-cycle writebacks, an optional hardwired-zero register 0, and a sequenced clear engine. Sits between decode (read and reserve) and writeback (write) in the datapath.

## Interface
- DATA_WIDTH, 16, register width in bits
- ADDR_WIDTH, 4, register index width; DEPTH = 2**ADDR_WIDTH
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes and reserves
- clock  in  1  sole clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- read_register1, read_register2  in  ADDR_WIDTH  read indices
- out1, out2  out  DATA_WIDTH  read data, combinational
- busy1, busy2  out  1  busy bit of read_register1 / read_register2, combinational
- regWrite_signal  in  1  write enable
- write_register  in  ADDR_WIDTH  write index
- write_value  in  DATA_WIDTH  write data
- reserve_valid  in  1  mark reserve_register busy (pending writeback)
- reserve_register  in  ADDR_WIDTH  index to reserve
- clear_start  in  1  one-cycle pulse, starts sequenced clear
- clear_busy  out  1  high while clear sequence runs

## Operation
- Storage: DEPTH x DATA_WIDTH flops plus DEPTH busy bits.
- Read: outN = register[read_registerN]; busyN = busy[read_registerN]. With ZERO_REG=1 and index 0: outN = 0, busyN = 0.
- Write: on posedge with regWrite_signal=1, register[write_register] <= write_value and busy[write_register] <= 0.
- Reserve: on posedge with reserve_valid=1, busy[reserve_register] <= 1.
- Same-edge reserve and write to same index: data written, busy ends 1 (reserve wins; new producer issued).
- ZERO_REG=1: writes/reserves to index 0 are dropped.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_start=1; counter <= 0; all busy bits cleared on that edge.
  - CLEAR: each cycle register[counter] <= 0, counter++; after writing DEPTH-1 -> IDLE.
  - In CLEAR: regWrite_signal, reserve_valid, clear_start ignored; reads stay functional and return the mixed cleared/uncleared contents.
  - clear_busy = 1 exactly in CLEAR.
- Reset (reset_n=0, any time, including mid-CLEAR): all registers 0, all busy 0, FSM IDLE, counter 0 immediately.

## Timing
- Reset values: out1=out2=0, busy1=busy2=0, clear_busy=0.
- Read latency 0 (combinational on index and state).
- Write visible on outN the cycle after the write edge (without bypass).
- Reserve visible on busyN the cycle after the reserve edge.
- clear_start at edge T: clear_busy high T+1 .. T+DEPTH; register k zeroed at edge T+1+k; writes accepted again from edge T+DEPTH+1.
- Counter width ADDR_WIDTH; terminal detect on counter == DEPTH-1, no wrap into register 0.

## Configuration
- REGFILE_BYPASS_EN defined: when regWrite_signal=1, not in CLEAR, write accepted (not dropped by ZERO_REG), and read_registerN == write_register, outN = write_value and busyN = 0 in the same cycle (reserve to that index on the same edge does not affect the bypassed busyN).
- Undefined: no bypass; outN/busyN show pre-edge state until the write edge.

## Test plan
- Reset: drive reset_n=0 mid-run after writing 0xBEEF to r5 -> out1 of r5 reads 0x0000 immediately, busy1=0, clear_busy=0.
- Write/read: write 0x1234 to r3, 0xABCD to r15; read r3/r15 next cycle -> out1=0x1234, out2=0xABCD; with ZERO_REG=1 write 0xFFFF to r0 -> out1=0.
- Scoreboard: reserve r7 -> busy1=1 next cycle; write 0x0042 to r7 -> busy1=0, out1=0x0042; same-edge reserve+write r7 -> out1=0x0042, busy1=1.
- Bypass (REGFILE_BYPASS_EN): write 0x5A5A to r9 while reading r9 -> out1=0x5A5A same cycle; without macro out1 shows old value until after edge.
- Clear: fill all 16 regs with nonzero, pulse clear_start -> clear_busy high 16 cycles, regs zero in order 0..15, write during CLEAR dropped, write after clear_busy falls lands.
- Reset mid-clear: assert reset_n=0 at clear cycle 6 -> clear_busy=0, all regs 0, FSM IDLE, next write accepted.

Source files
------------

// File: rtl/param_register_file_if.sv
// ============================================================================
// Module   : param_register_file_if
// Purpose  : Read, write, reserve and clear signal bundle for param_register_file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_register_file_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] read_register1;
  logic [ADDR_WIDTH-1:0] read_register2;
  logic [DATA_WIDTH-1:0] out1;
  logic [DATA_WIDTH-1:0] out2;
  logic                  busy1;
  logic                  busy2;
  logic                  regWrite_signal;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_value;
  logic                  reserve_valid;
  logic [ADDR_WIDTH-1:0] reserve_register;
  logic                  clear_start;
  logic                  clear_busy;

  modport master (
    output read_register1, read_register2,
    output regWrite_signal, write_register, write_value,
    output reserve_valid, reserve_register, clear_start,
    input  out1, out2, busy1, busy2, clear_busy
  );

  modport slave (
    input  read_register1, read_register2,
    input  regWrite_signal, write_register, write_value,
    input  reserve_valid, reserve_register, clear_start,
    output out1, out2, busy1, busy2, clear_busy
  );
endinterface

`default_nettype wire

// File: rtl/param_register_file.sv
// ============================================================================
// Module   : param_register_file
// Purpose  : Parametrised 2R/1W register file with busy scoreboard, optional
//            hardwired-zero r0 and sequenced clear. Define REGFILE_BYPASS_EN
//            to forward same-cycle write data onto the read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 0
) (
  input  wire logic            clock,
  input  wire logic            reset_n,
  param_register_file_if.slave rf
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_last    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_r0      = '0;
  localparam bit                    c_zero_en = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;

  logic w_in_clear;
  logic w_start;
  logic w_wr_acc;
  logic w_rsv_acc;

  assign w_in_clear    = (state_q == S_CLEAR);
  assign rf.clear_busy = w_in_clear;

  // Clear engine owns the register file; host writes and reserves are dropped.
  assign w_wr_acc  = rf.regWrite_signal && !w_in_clear &&
                     !(c_zero_en && (rf.write_register == c_r0));
  assign w_rsv_acc = rf.reserve_valid && !w_in_clear &&
                     !(c_zero_en && (rf.reserve_register == c_r0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rf.clear_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          w_start = 1'b1;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reserve is applied after write so a same-edge reserve leaves the bit set.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w_in_clear) begin
      regs_d[cnt_q] = '0;
    end else if (w_wr_acc) begin
      regs_d[rf.write_register] = rf.write_value;
      busy_d[rf.write_register] = 1'b0;
    end
    if (w_start) begin
      busy_d = '0;
    end else if (w_rsv_acc) begin
      busy_d[rf.reserve_register] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rf.out1  = regs_q[rf.read_register1];
    rf.busy1 = busy_q[rf.read_register1];
    rf.out2  = regs_q[rf.read_register2];
    rf.busy2 = busy_q[rf.read_register2];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_acc && (rf.read_register1 == rf.write_register)) begin
      rf.out1  = rf.write_value;
      rf.busy1 = 1'b0;
    end
    if (w_wr_acc && (rf.read_register2 == rf.write_register)) begin
      rf.out2  = rf.write_value;
      rf.busy2 = 1'b0;
    end
`else
`endif
    if (c_zero_en && (rf.read_register1 == c_r0)) begin
      rf.out1  = '0;
      rf.busy1 = 1'b0;
    end
    if (c_zero_en && (rf.read_register2 == c_r0)) begin
      rf.out2  = '0;
      rf.busy2 = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_param_register_file.sv
// ============================================================================
// Module   : tb_param_register_file
// Purpose  : Directed scoreboard bench for param_register_file (ZERO_REG=1 and
//            ZERO_REG=0 instances sharing one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int OUT1 = 0, OUT2 = 1, BUSY1 = 2, BUSY2 = 3, CLRB = 4, NZ_OUT1 = 5, NZ_BUSY1 = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  param_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();
  param_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus_nz ();

  param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1)) u_dut (
    .clock   (clk),
    .reset_n (rst_n),
    .rf      (bus.slave)
  );

  param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(0)) u_dut_nz (
    .clock   (clk),
    .reset_n (rst_n),
    .rf      (bus_nz.slave)
  );

  assign bus_nz.read_register1   = bus.read_register1;
  assign bus_nz.read_register2   = bus.read_register2;
  assign bus_nz.regWrite_signal  = bus.regWrite_signal;
  assign bus_nz.write_register   = bus.write_register;
  assign bus_nz.write_value      = bus.write_value;
  assign bus_nz.reserve_valid    = bus.reserve_valid;
  assign bus_nz.reserve_register = bus.reserve_register;
  assign bus_nz.clear_start      = bus.clear_start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] val(input int k);
    return 16'hC001 + 16'(k) * 16'h0101;
  endfunction

  function automatic logic [15:0] sample(input int sel);
    case (sel)
      OUT1:     return bus.out1;
      OUT2:     return bus.out2;
      BUSY1:    return {15'd0, bus.busy1};
      BUSY2:    return {15'd0, bus.busy2};
      CLRB:     return {15'd0, bus.clear_busy};
      NZ_OUT1:  return bus_nz.out1;
      NZ_BUSY1: return {15'd0, bus_nz.busy1};
      default:  return 16'hxxxx;
    endcase
  endfunction

  // Monitor: drains every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = sb.pop_front();
      act = sample(e.sel);
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.regWrite_signal = 1'b0;
    bus.reserve_valid   = 1'b0;
    bus.clear_start     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] v);
    bus.regWrite_signal = 1'b1;
    bus.write_register  = a;
    bus.write_value     = v;
  endtask

  task automatic rsv(input logic [3:0] a);
    bus.reserve_valid    = 1'b1;
    bus.reserve_register = a;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.write_register   = '0;
    bus.write_value      = '0;
    bus.reserve_register = '0;
    bus.read_register1   = 4'd5;
    bus.read_register2   = 4'd9;
    tick();
    chk("reset_out1", OUT1, 16'h0000);
    chk("reset_out2", OUT2, 16'h0000);
    chk("reset_busy1", BUSY1, 16'h0);
    chk("reset_busy2", BUSY2, 16'h0);
    chk("reset_clear_busy", CLRB, 16'h0);
    tick();
    rst_n = 1'b1;

    // Mid-run reset after a write and a reserve
    wr(4'd5, 16'hBEEF); rsv(4'd6);
    bus.read_register1 = 4'd5; bus.read_register2 = 4'd6;
    tick();
    chk("pre_reset_out1", OUT1, 16'hBEEF);
    chk("pre_reset_busy2", BUSY2, 16'h1);
    tick();
    rst_n = 1'b0;
    chk("midrun_reset_out1", OUT1, 16'h0000);
    chk("midrun_reset_busy2", BUSY2, 16'h0);
    chk("midrun_reset_clear_busy", CLRB, 16'h0);
    tick();
    rst_n = 1'b1;

    // Write / read
    wr(4'd3, 16'h1234); tick();
    wr(4'd15, 16'hABCD); tick();
    bus.read_register1 = 4'd3; bus.read_register2 = 4'd15;
    chk("rd_r3", OUT1, 16'h1234);
    chk("rd_r15", OUT2, 16'hABCD);
    tick();

    // Hardwired zero register
    bus.read_register1 = 4'd0;
    wr(4'd0, 16'hFFFF); rsv(4'd0);
    chk("zr_bypass_r0", OUT1, 16'h0000);
    chk("nz_pre_edge_r0", NZ_OUT1, BYP ? 16'hFFFF : 16'h0000);
    tick();
    chk("zr_out1_r0", OUT1, 16'h0000);
    chk("zr_busy1_r0", BUSY1, 16'h0);
    chk("nz_out1_r0", NZ_OUT1, 16'hFFFF);
    chk("nz_busy1_r0", NZ_BUSY1, 16'h1);
    tick();

    // Busy scoreboard
    rsv(4'd7); tick();
    bus.read_register1 = 4'd7;
    chk("rsv_busy1", BUSY1, 16'h1);
    tick();
    wr(4'd7, 16'h0042);
    chk("wr_same_cycle_out1", OUT1, BYP ? 16'h0042 : 16'h0000);
    chk("wr_same_cycle_busy1", BUSY1, BYP ? 16'h0 : 16'h1);
    tick();
    chk("wr_out1", OUT1, 16'h0042);
    chk("wr_busy1", BUSY1, 16'h0);
    wr(4'd7, 16'h0077); rsv(4'd7);
    chk("rsvwr_same_cycle_out1", OUT1, BYP ? 16'h0077 : 16'h0042);
    chk("rsvwr_same_cycle_busy1", BUSY1, 16'h0);
    tick();
    chk("rsvwr_out1", OUT1, 16'h0077);
    chk("rsvwr_busy1", BUSY1, 16'h1);
    tick();

    // Bypass behaviour
    bus.read_register1 = 4'd9;
    wr(4'd9, 16'h5A5A);
    chk("byp_same_cycle_r9", OUT1, BYP ? 16'h5A5A : 16'h0000);
    tick();
    chk("byp_after_edge_r9", OUT1, 16'h5A5A);
    tick();

    // Sequenced clear
    for (int k = 0; k < 16; k++) begin
      wr(4'(k), val(k));
      if (k == 2) rsv(4'd2);
      tick();
    end
    bus.read_register2 = 4'd2;
    chk("pre_clear_busy2", BUSY2, 16'h1);
    chk("pre_clear_clear_busy", CLRB, 16'h0);
    bus.clear_start = 1'b1;
    tick();
    for (int j = 0; j < 16; j++) begin
      bus.read_register1 = 4'(j);
      bus.read_register2 = (j == 0) ? 4'd2 : 4'(j - 1);
      chk($sformatf("clr%0d_clear_busy", j), CLRB, 16'h1);
      chk($sformatf("clr%0d_pending", j), OUT1, (j == 0) ? 16'h0000 : val(j));
      chk($sformatf("clr%0d_nz_pending", j), NZ_OUT1, val(j));
      if (j == 0) chk("clr0_busy_cleared", BUSY2, 16'h0);
      else        chk($sformatf("clr%0d_done", j), OUT2, 16'h0000);
      if (j == 5)  bus.clear_start = 1'b1;
      if (j == 15) begin
        wr(4'd3, 16'hDEAD);
        rsv(4'd3);
      end
      tick();
    end
    bus.read_register1 = 4'd15; bus.read_register2 = 4'd3;
    chk("post_clear_clear_busy", CLRB, 16'h0);
    chk("post_clear_r15", OUT1, 16'h0000);
    chk("clear_dropped_write", OUT2, 16'h0000);
    chk("clear_dropped_reserve", BUSY2, 16'h0);
    wr(4'd14, 16'h7777);
    tick();
    bus.read_register1 = 4'd14;
    chk("first_write_after_clear", OUT1, 16'h7777);
    tick();

    // Reset in the middle of a clear
    wr(4'd10, 16'hA10A); tick();
    wr(4'd12, 16'hC12C); tick();
    bus.clear_start = 1'b1;
    tick();
    repeat (5) tick();
    bus.read_register1 = 4'd10; bus.read_register2 = 4'd12;
    chk("midclr_clear_busy", CLRB, 16'h1);
    chk("midclr_r10", OUT1, 16'hA10A);
    tick();
    rst_n = 1'b0;
    chk("midclr_reset_clear_busy", CLRB, 16'h0);
    chk("midclr_reset_r10", OUT1, 16'h0000);
    chk("midclr_reset_r12", OUT2, 16'h0000);
    tick();
    rst_n = 1'b1;
    wr(4'd10, 16'h3C3C); tick();
    wr(4'd6, 16'h6666);
    chk("after_reset_write", OUT1, 16'h3C3C);
    chk("after_reset_idle", CLRB, 16'h0);
    tick();
    bus.clear_start = 1'b1;
    tick();
    tick();
    bus.read_register1 = 4'd6; bus.read_register2 = 4'd0;
    chk("counter_restart_r6", OUT1, 16'h6666);
    chk("counter_restart_busy", CLRB, 16'h1);
    tick();
    begin
      int n;
      for (n = 0; n < 40; n++) begin
        if (!bus.clear_busy) break;
        tick();
      end
      if (n == 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL clear_timeout: clear_busy %b after 40 cycles, expected 0", bus.clear_busy);
      end
    end
    chk("final_r6_cleared", OUT1, 16'h0000);
    tick();

    for (int n = 0; n < 10; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
